m_div_unit: RTL and testbench
=============================

// Module: m_div_unit
// PURPOSE
//  Parametrised iterative integer divider for the M-extension execute stage; successor to the fixed 32-bit unsigned divider.
//  Performs signed/unsigned DIV/REM (RISC-V semantics) with valid/ready handshakes, in-order tag return and flush support.
//  Retires BITS_PER_CYCLE quotient bits per cycle using a restoring shift-subtract datapath on operand magnitudes.
// PARAMETERS
//  XLEN            32  operand/result width; even, >= 8
//  BITS_PER_CYCLE  1   quotient bits per CALC cycle; 1, 2 or 4; must divide XLEN
//  TAG_W           5   width of opaque tag (destination register id) carried with the op
// PORTS
//  clk           in   1       clock, all state on rising edge
//  clr_n         in   1       asynchronous active-low reset
//  flush         in   1       synchronous kill of the in-flight op
//  in_valid      in   1       request valid
//  in_ready      out  1       unit can accept a request
//  in_op         in   2       div_op_e: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  in_dividend   in   XLEN    dividend
//  in_divisor    in   XLEN    divisor
//  in_tag        in   TAG_W   tag returned with result
//  out_valid     out  1       result valid
//  out_ready     in   1       consumer accepts result
//  out_result    out  XLEN    quotient or remainder per op
//  out_tag       out  TAG_W   tag of the completed op
//  out_div_zero  out  1       divisor was zero
//  out_overflow  out  1       signed overflow (-2^(XLEN-1) / -1)
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (clr_n low, async): state IDLE; out_valid, out_div_zero, out_overflow, busy = 0; out_result, out_tag = 0.
//  FSM: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//  IDLE:
//    - in_ready = !flush.
//    - On accept: latch op, tag, sign flags, |dividend|, |divisor| (unsigned ops: raw); iteration counter = 0.
//    - Go to CALC.
//  CALC: each cycle performs BITS_PER_CYCLE restoring steps on a (2*XLEN)-bit partial remainder; after XLEN/BITS_PER_CYCLE cycles go to FIXUP.
//  FIXUP:
//    - Signed ops negate quotient iff dividend and divisor signs differ; negate remainder iff dividend negative.
//    - Select result by op; register outputs; go to DONE.
//  DONE:
//    - out_valid = 1; outputs held stable until out_ready.
//    - in_ready = out_ready && !flush: a back-to-back accept in the retire cycle goes directly to CALC.
//  Latency accept -> out_valid = XLEN/BITS_PER_CYCLE + 2 cycles; throughput one op per XLEN/BITS_PER_CYCLE + 2 cycles.
//  Divisor zero: DIV/DIVU -> all ones; REM/REMU -> dividend; out_div_zero = 1.
//  Overflow (DIV/REM only, dividend = 0x80..0, divisor = all ones): DIV -> dividend; REM -> 0; out_overflow = 1.
//  Without early-out, special cases run the full iteration count and override the result in FIXUP (constant timing).
//  Flush (any state):
//    - Next state IDLE; out_valid = 0; no result is produced for the killed op.
//    - An in_valid present in the flush cycle is not accepted.
//  Reset mid-op discards everything; first cycle after release is IDLE with in_ready = 1.
//  Flags are valid only while out_valid = 1.
// CONFIGURATION
//  Macro M_DIV_EARLY_OUT_EN:
//    - Defined: divisor zero, signed overflow, divisor == 1, and |dividend| < |divisor| bypass CALC.
//    - Bypass path: accept -> FIXUP -> DONE, so out_valid follows 2 cycles after accept; results identical to the full path.
//    - Undefined: every op takes the full latency.
// STRUCTURE
//  Package m_div_pkg:
//    - div_op_e (2-bit enum), div_state_e (IDLE, CALC, FIXUP, DONE).
//    - Helper function is_signed_op().
//  Sub-module m_div_step: combinational single restoring step (partial remainder, divisor, quotient-in -> partial remainder-out, quotient-out).
//  m_div_step is instantiated BITS_PER_CYCLE times in a generate chain inside CALC.
// TESTING
//  - DIVU 100 / 7 -> out_result 14 after 34 cycles (XLEN 32, BPC 1); REMU same operands -> 2; tag echoed.
//  - DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
//  - DIVU 5 / 0 -> 0xFFFFFFFF, div_zero = 1; REM 0x80000000 / 0xFFFFFFFF -> 0, overflow = 1.
//  - Hold out_ready low 10 cycles -> out_valid and result stable, in_ready low.
//  - Raise out_ready with in_valid high -> retire and accept in the same cycle.
//  - Flush at CALC cycle 5 -> out_valid never rises; next op 9 / 3 -> 3.
//  - clr_n low mid-CALC -> all outputs 0 immediately.
//  - M_DIV_EARLY_OUT_EN defined: 3 / 10 -> quotient 0, out_valid 2 cycles after accept.
//  - Random signed/unsigned ops vs. reference model for BITS_PER_CYCLE 1, 2, 4.

Source files
------------

// File: rtl/m_div_pkg.sv
// Shared types and helpers for the iterative M-extension divider.
package m_div_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } div_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/m_div_unit_if.sv
// Request/response handshake bundle of the divider; slave = divider, master = issuer.
interface m_div_unit_if
  import m_div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  div_op_e          in_op;
  logic [XLEN-1:0]  in_dividend;
  logic [XLEN-1:0]  in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_div_zero;
  logic             out_overflow;
  logic             busy;

  modport slave (
    input  flush, in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_div_zero, out_overflow, busy
  );

  modport master (
    output flush, in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_div_zero, out_overflow, busy
  );

endinterface

// File: rtl/m_div_step.sv
// One restoring shift-subtract step: remainder lives in the upper half of pr, dividend
// bits shift out of the lower half.
module m_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] pr_i,
  input  logic [XLEN-1:0]   divisor_i,
  input  logic [XLEN-1:0]   quo_i,
  output logic [2*XLEN-1:0] pr_o,
  output logic [XLEN-1:0]   quo_o
);

  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] upper;
  logic            q_bit;

  always_comb begin
    // One extra bit: the shifted remainder may reach 2*divisor - 1.
    trial = pr_i[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, divisor_i};
    q_bit = (trial >= {1'b0, divisor_i});
    upper = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    pr_o  = {upper, pr_i[XLEN-2:0], 1'b0};
    quo_o = {quo_i[XLEN-2:0], q_bit};
  end

endmodule

// File: rtl/m_div_unit.sv
// Iterative signed/unsigned DIV/REM unit with tag return and flush.
// Optional M_DIV_EARLY_OUT_EN: trivial operand cases skip CALC and go straight to FIXUP.
module m_div_unit
  import m_div_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input logic         clk,
  input logic         clr_n,
  m_div_unit_if.slave bus
);

  localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state_q, state_d;
  div_op_e           op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d, otag_q, otag_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic              dz_q, dz_d, ov_q, ov_d, odz_q, odz_d, oov_q, oov_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d, b_mag_q, b_mag_d, quo_q, quo_d, res_q, res_d;
  logic [2*XLEN-1:0] pr_q, pr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              in_ready, out_valid, sgn_in, a_neg_in, b_neg_in, dz_in, ov_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, rem_mag, quo_fix, rem_fix, fix_result;

  logic [2*XLEN-1:0] pr_chain  [BITS_PER_CYCLE+1];
  logic [XLEN-1:0]   quo_chain [BITS_PER_CYCLE+1];

  assign pr_chain[0]  = pr_q;
  assign quo_chain[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    m_div_step #(.XLEN(XLEN)) u_step (
      .pr_i      (pr_chain[g]),
      .divisor_i (b_mag_q),
      .quo_i     (quo_chain[g]),
      .pr_o      (pr_chain[g+1]),
      .quo_o     (quo_chain[g+1])
    );
  end

  always_comb begin
    sgn_in   = is_signed_op(bus.in_op);
    a_neg_in = sgn_in & bus.in_dividend[XLEN-1];
    b_neg_in = sgn_in & bus.in_divisor[XLEN-1];
    a_mag_in = a_neg_in ? -bus.in_dividend : bus.in_dividend;
    b_mag_in = b_neg_in ? -bus.in_divisor : bus.in_divisor;
    dz_in    = (bus.in_divisor == '0);
    ov_in    = sgn_in && (bus.in_dividend == MinNeg) && (bus.in_divisor == '1);
  end

  // Sign restoration and special-case override of the magnitude result.
  always_comb begin
    rem_mag = pr_q[2*XLEN-1:XLEN];
    quo_fix = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_fix = a_neg_q ? -rem_mag : rem_mag;
    if (dz_q) begin
      fix_result = is_rem_op(op_q) ? a_raw_q : '1;
    end else if (ov_q) begin
      fix_result = is_rem_op(op_q) ? '0 : a_raw_q;
    end else begin
      fix_result = is_rem_op(op_q) ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    a_raw_d   = a_raw_q;
    b_mag_d   = b_mag_q;
    pr_d      = pr_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    otag_d    = otag_q;
    odz_d     = odz_q;
    oov_d     = oov_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: in_ready = ~bus.flush;
      StCalc: begin
        pr_d  = pr_chain[BITS_PER_CYCLE];
        quo_d = quo_chain[BITS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Steps - 1)) state_d = StFixup;
      end
      StFixup: begin
        res_d   = fix_result;
        otag_d  = tag_q;
        odz_d   = dz_q;
        oov_d   = ov_q;
        state_d = StDone;
      end
      StDone: begin
        out_valid = ~bus.flush;
        in_ready  = bus.out_ready & ~bus.flush;
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (in_ready && bus.in_valid) begin
      op_d    = bus.in_op;
      tag_d   = bus.in_tag;
      a_neg_d = a_neg_in;
      b_neg_d = b_neg_in;
      dz_d    = dz_in;
      ov_d    = ov_in;
      a_raw_d = bus.in_dividend;
      b_mag_d = b_mag_in;
      pr_d    = {{XLEN{1'b0}}, a_mag_in};
      quo_d   = '0;
      cnt_d   = '0;
      state_d = StCalc;
`ifdef M_DIV_EARLY_OUT_EN
      // Preload the magnitude quotient/remainder so FIXUP sees what CALC would produce.
      if (dz_in || ov_in || (b_mag_in == XLEN'(1))) begin
        quo_d   = a_mag_in;
        pr_d    = '0;
        state_d = StFixup;
      end else if (a_mag_in < b_mag_in) begin
        quo_d   = '0;
        pr_d    = {a_mag_in, {XLEN{1'b0}}};
        state_d = StFixup;
      end
`endif
    end

    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      op_q    <= OpDiv;
      tag_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      a_raw_q <= '0;
      b_mag_q <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      otag_q  <= '0;
      odz_q   <= 1'b0;
      oov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      a_raw_q <= a_raw_d;
      b_mag_q <= b_mag_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
      odz_q   <= odz_d;
      oov_q   <= oov_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_result   = res_q;
  assign bus.out_tag      = otag_q;
  assign bus.out_div_zero = odz_q & out_valid;
  assign bus.out_overflow = oov_q & out_valid;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_m_div_unit.sv
// Self-checking bench for m_div_unit: directed corner cases, handshake/flush/reset, random ops.
module tb_m_div_unit #(
  parameter int unsigned BPC = 1
);
  import m_div_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int          NSTEPS = XLEN / BPC;

  logic clk = 1'b0;
  logic clr_n;
  int   n_total = 0;
  int   n_bad   = 0;

  m_div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  m_div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain RISC-V division semantics on integers.
  function automatic void ref_model(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic dz, output logic ov);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = (b == 32'd0);
    ov = (op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (dz) res = (op == OpDiv || op == OpDivu) ? 32'hFFFF_FFFF : a;
    else if (ov) res = (op == OpDiv) ? a : 32'd0;
    else begin
      case (op)
        OpDiv:   res = 32'(sa / sb);
        OpRem:   res = 32'(sa % sb);
        OpDivu:  res = a / b;
        default: res = a % b;
      endcase
    end
  endfunction

  function automatic logic bypass(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    logic   sgn;
    sgn = (op == OpDiv || op == OpRem);
    ma  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || mb == 1 || ma < mb;
  endfunction

  task automatic send(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    int k = 0;
    bus.in_op = op;
    bus.in_dividend = a;
    bus.in_divisor = b;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check_eq("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input div_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input logic [31:0] er,
                           input logic edz, input logic eov);
    int lat;
    int el = NSTEPS + 2;
`ifdef M_DIV_EARLY_OUT_EN
    if (bypass(op, a, b)) el = 2;
`endif
    send(op, a, b, tag);
    wait_done(lat);
    check_eq({name, "_lat"}, 64'(lat), 64'(el));
    check_eq({name, "_res"}, 64'(bus.out_result), 64'(er));
    check_eq({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    check_eq({name, "_dz"}, 64'(bus.out_div_zero), 64'(edz));
    check_eq({name, "_ov"}, 64'(bus.out_overflow), 64'(eov));
    retire();
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({name, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({name, "_result"}, 64'(bus.out_result), 64'd0);
    check_eq({name, "_tag"}, 64'(bus.out_tag), 64'd0);
    check_eq({name, "_dz"}, 64'(bus.out_div_zero), 64'd0);
    check_eq({name, "_ov"}, 64'(bus.out_overflow), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [31:0] a, b, er;
    logic edz, eov;
    div_op_e op;

    clr_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = OpDiv;
    bus.in_dividend = '0;
    bus.in_divisor = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk) clr_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    run_check("divu_100_7", OpDivu, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 1'b0);
    run_check("remu_100_7", OpRemu, 32'd100, 32'd7, 5'd9, 32'd2, 1'b0, 1'b0);
    run_check("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_check("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_check("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'd1, 1'b0, 1'b0);
    run_check("divu_5_0", OpDivu, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_check("remu_5_0", OpRemu, 32'd5, 32'd0, 5'd6, 32'd5, 1'b1, 1'b0);
    run_check("div_m5_0", OpDiv, 32'hFFFF_FFFB, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_check("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b0, 1'b1);
    run_check("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b0, 1'b1);
    run_check("divu_3_10", OpDivu, 32'd3, 32'd10, 5'd11, 32'd0, 1'b0, 1'b0);
    run_check("div_m9_1", OpDiv, 32'hFFFF_FFF7, 32'd1, 5'd12, 32'hFFFF_FFF7, 1'b0, 1'b0);

    // Backpressure: result held stable, no new accept while stalled.
    send(OpDivu, 32'd1000, 32'd7, 5'd13);
    wait_done(lat);
    check_eq("stall_first", 64'(bus.out_result), 64'd142);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stall_result", 64'(bus.out_result), 64'd142);
      check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end

    // Retire and accept in the same cycle.
    bus.in_op = OpDiv;
    bus.in_dividend = 32'hFFFF_FF9C;
    bus.in_divisor = 32'd7;
    bus.in_tag = 5'd14;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("b2b_valid_low", 64'(bus.out_valid), 64'd0);
    check_eq("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check_eq("b2b_lat", 64'(lat), 64'(NSTEPS + 2));
    check_eq("b2b_result", 64'(bus.out_result), 64'hFFFF_FFF2);
    check_eq("b2b_tag", 64'(bus.out_tag), 64'd14);
    retire();

    // Flush while idle blocks the accept.
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check_eq("flush_idle_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_idle_busy", 64'(bus.busy), 64'd0);

    // Flush in CALC cycle 5 kills the op.
    send(OpDivu, 32'd1000, 32'd7, 5'd15);
    repeat (4) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check_eq("flush_calc_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_calc_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int i = 0; i < NSTEPS + 20; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);
    run_check("after_flush_9_3", OpDivu, 32'd9, 32'd3, 5'd16, 32'd3, 1'b0, 1'b0);

    // Asynchronous reset mid-CALC clears everything at once.
    send(OpDivu, 32'hDEAD_BEEF, 32'd3, 5'd17);
    repeat (3) begin @(posedge clk); #1; end
    #2 clr_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk) clr_n = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Random ops against the reference model, biased towards corner operands.
    for (int i = 0; i < 150; i++) begin
      op = div_op_e'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 20));
        4: b = 32'($urandom_range(1, 3)) << $urandom_range(0, 31);
        default: ;
      endcase
      ref_model(op, a, b, er, edz, eov);
      run_check("rand", op, a, b, 5'($urandom_range(0, 31)), er, edz, eov);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
